wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Register-file write-back arbiter for a pipeline (port A) and a multi-cycle
// unit (port B).
//
// Port A is never back-pressured. Its write reaches the output registers one
// cycle after it is presented. Port B results are buffered in a 2-entry FIFO.
// The FIFO head is written back only in cycles in which port A is idle.
//
// A 32-bit pending scoreboard tracks port B destinations that have been issued
// but not yet written. It raises a combinational stall request for decode.
//
// Configuration macro:
//   WB_FIFO_BYPASS_EN - when defined, a port B result that arrives while the
//                       FIFO is empty and port A is idle skips the FIFO
//                       (1-cycle latency). When undefined, every port B
//                       result passes through the FIFO (2-cycle minimum).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   a_we/a_waddr/a_wdata  port A write (register 0 is dropped)
//   b_valid/b_waddr/b_wdata, b_ready  port B result handshake
//   b_issue, b_issue_addr  decode issuing a port B operation (sets pending)
//   re1/raddr1, re2/raddr2, id_waddr_chk  decode hazard check inputs
//   stallreq            decode must stall
//   we/waddr/wdata      registered register-file write
// -----------------------------------------------------------------------------
module wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_we,
    input  logic [4:0]  a_waddr,
    input  logic [31:0] a_wdata,
    input  logic        b_valid,
    input  logic [4:0]  b_waddr,
    input  logic [31:0] b_wdata,
    output logic        b_ready,
    input  logic        b_issue,
    input  logic [4:0]  b_issue_addr,
    input  logic        re1,
    input  logic        re2,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    input  logic [4:0]  id_waddr_chk,
    output logic        stallreq,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata
);

    // FIFO state
    logic [4:0]  fifo_addr_q [2];
    logic [31:0] fifo_data_q [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;

    // Output registers
    logic        we_q, we_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;

    // Pending scoreboard; bit 0 is never stored
    logic [31:1] pend_q;
    logic [31:0] pending;

    logic a_act;
    logic b_hs;
    logic b_keep;
    logic deq;
    logic enq;
    logic bypass;
    logic b_load;

    assign a_act  = a_we && (a_waddr != 5'd0);
    // Ready depends only on the registered count, so it never waits on b_valid.
    assign b_ready = rst || (count_q != 2'd2);
    assign b_hs   = b_valid && b_ready;
    // Register-0 results complete the handshake but are never stored.
    assign b_keep = b_hs && (b_waddr != 5'd0);
    assign deq    = !a_act && (count_q != 2'd0);

`ifdef WB_FIFO_BYPASS_EN
    assign bypass = !a_act && (count_q == 2'd0) && b_keep;
`else
    assign bypass = 1'b0;
`endif

    assign enq = b_keep && !bypass;

    // Write selection: port A first, then the FIFO head, then the bypass path.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = 5'd0;
        wdata_d = 32'd0;
        b_load  = 1'b0;
        if (a_act) begin
            we_d    = 1'b1;
            waddr_d = a_waddr;
            wdata_d = a_wdata;
        end else if (deq) begin
            we_d    = 1'b1;
            waddr_d = fifo_addr_q[rd_ptr_q];
            wdata_d = fifo_data_q[rd_ptr_q];
            b_load  = 1'b1;
        end else if (bypass) begin
            we_d    = 1'b1;
            waddr_d = b_waddr;
            wdata_d = b_wdata;
            b_load  = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ enq;
        rd_ptr_d = rd_ptr_q ^ deq;
        count_d  = count_q;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            waddr_q  <= 5'd0;
            wdata_q  <= 32'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage needs no reset: the pointer and count reset discard it.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            always_ff @(posedge clk) begin
                if (enq && (wr_ptr_q == 1'(gi))) begin
                    fifo_addr_q[gi] <= b_waddr;
                    fifo_data_q[gi] <= b_wdata;
                end
            end
        end
    endgenerate

    // Pending bits: a bit is cleared on the edge that loads its port B write
    // into the output registers. A same-cycle issue to that bit takes priority.
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_pend
            logic set_bit;
            logic clr_bit;
            assign set_bit = b_issue && (b_issue_addr == 5'(gi));
            assign clr_bit = b_load && (waddr_d == 5'(gi));
            always_ff @(posedge clk) begin
                if (rst) begin
                    pend_q[gi] <= 1'b0;
                end else if (set_bit) begin
                    pend_q[gi] <= 1'b1;
                end else if (clr_bit) begin
                    pend_q[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign pending = {pend_q, 1'b0};

    // The pending bit is already clear in the cycle that writes the register.
    // The register file forwards wdata in that cycle, so no extra term is needed.
    assign stallreq = !rst && ((re1 && pending[raddr1]) ||
                               (re2 && pending[raddr2]) ||
                               pending[id_waddr_chk]);

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

endmodule
